// File: rtl/axi_burst_read_responder.sv
// AXI4-style INCR-burst read responder backed by a preloadable 32-bit word RAM.
// Accepts one AR request at a time and streams beats after a fixed latency.
module axi_burst_read_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           araddr,
  input  logic [7:0]            arlen,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [31:0]           rdata,
  output logic                  rvalid,
  output logic                  rlast,
  input  logic                  rready,
  output logic                  busy,
  input  logic                  init_we,
  input  logic [DEPTH_LOG2-1:0] init_addr,
  input  logic [31:0]           init_data
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

  state_t                state;
  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] idx;
  logic [DEPTH_LOG2-1:0] idx_next;
  logic [7:0]            beats_left;
  logic [3:0]            lat_cnt;
  logic                  unused_araddr;

  // Word index wraps naturally at the RAM depth, so the address space aliases.
  assign idx_next      = idx + 1'b1;
  assign unused_araddr = ^{araddr[31:DEPTH_LOG2+2], araddr[1:0]};

  // Preload only while idle so an in-flight burst never sees its data change.
  always_ff @(posedge clk) begin
    if (init_we && state == IDLE)
      mem[init_addr] <= init_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      arready    <= 1'b1;
      busy       <= 1'b0;
      rvalid     <= 1'b0;
      rlast      <= 1'b0;
      rdata      <= '0;
      idx        <= '0;
      beats_left <= '0;
      lat_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arvalid) begin
            idx        <= araddr[DEPTH_LOG2+1:2];
            beats_left <= arlen;
            lat_cnt    <= 4'(LATENCY - 1);
            arready    <= 1'b0;
            busy       <= 1'b1;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == 4'd0) begin
            rdata  <= mem[idx];
            rvalid <= 1'b1;
            rlast  <= (beats_left == 8'd0);
            state  <= BURST;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        BURST: begin
          // Outputs hold while stalled; a handshake either ends the burst or advances one beat.
          if (rvalid && rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              busy    <= 1'b0;
              state   <= IDLE;
            end else begin
              idx        <= idx_next;
              beats_left <= beats_left - 8'd1;
              rdata      <= mem[idx_next];
              rlast      <= (beats_left == 8'd1);
            end
          end
        end
        default: begin
          state   <= IDLE;
          arready <= 1'b1;
          busy    <= 1'b0;
          rvalid  <= 1'b0;
          rlast   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_axi_burst_read_responder.sv
// Randomized self-checking bench for axi_burst_read_responder.
// Expected beats come from a word-array model indexed with plain modular arithmetic.
module tb_axi_burst_read_responder;
  localparam int DL    = 10;
  localparam int LAT   = 3;
  localparam int DEPTH = 2 ** DL;

  logic          clk;
  logic          rst;
  logic [31:0]   araddr;
  logic [7:0]    arlen;
  logic          arvalid;
  logic          arready;
  logic [31:0]   rdata;
  logic          rvalid;
  logic          rlast;
  logic          rready;
  logic          busy;
  logic          init_we;
  logic [DL-1:0] init_addr;
  logic [31:0]   init_data;

  logic [31:0]   refMem [DEPTH];
  int            checkCount;
  int            passCount;
  logic [31:0]   nextAddr;
  logic [7:0]    nextLen;
  logic [DL-1:0] junkIdx;

  axi_burst_read_responder #(.DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .araddr(araddr), .arlen(arlen), .arvalid(arvalid),
    .arready(arready), .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .rready(rready),
    .busy(busy), .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time exceeded, required completion before limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checkCount++;
    if (got === want) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
  endtask

  function automatic logic [31:0] expectedWord(input logic [31:0] addr, input int beat);
    int unsigned w;
    w = ((addr >> 2) + beat) % DEPTH;
    return refMem[w];
  endfunction

  task automatic loadWord(input int idx, input logic [31:0] data);
    init_we   = 1'b1;
    init_addr = DL'(idx);
    init_data = data;
    refMem[idx] = data;
    @(posedge clk); #1;
    init_we = 1'b0;
  endtask

  // One burst: rmode 0 = rready high, 1 = pattern 1,0,0, 2 = random.
  // holdAr keeps the next request pending (and pokes init_we) during the burst.
  // resetAfter > 0 asserts rst after that many accepted beats.
  task automatic applyStimulus(input logic [31:0] addr, input logic [7:0] len, input int rmode,
                               input bit holdAr, input int resetAfter);
    int beat, guard, phase, cyc, budget;
    bit done, aborted, accepted;
    arvalid = 1'b1;
    araddr  = addr;
    arlen   = len;
    checkOutput("arready_idle", arready, 1);
    @(posedge clk); #1;
    init_we = 1'b0;
    arvalid = holdAr;
    araddr  = nextAddr;
    arlen   = nextLen;
    checkOutput("busy_wait", busy, 1);
    cyc = 0;
    while (!rvalid && cyc < 40) begin
      checkOutput("arready_wait", arready, 0);
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("latency", cyc, LAT);
    beat = 0; guard = 0; phase = 0; done = 0; aborted = 0;
    budget = 8 * (int'(len) + 1) + 20;
    while (!done) begin
      if (guard > budget) begin
        checkOutput("burst_timeout", guard, budget);
        done = 1;
      end else begin
        case (rmode)
          0:       rready = 1'b1;
          1:       rready = (phase % 3 == 0);
          default: rready = 1'($urandom_range(0, 1));
        endcase
        phase++;
        if (holdAr) begin
          init_we   = 1'b1;
          init_addr = junkIdx;
          init_data = ~refMem[junkIdx];
          checkOutput("arready_burst", arready, 0);
          checkOutput("busy_burst", busy, 1);
        end
        checkOutput("rvalid", rvalid, 1);
        checkOutput("rdata", rdata, expectedWord(addr, beat));
        checkOutput("rlast", rlast, beat == int'(len));
        accepted = rready;
        @(posedge clk); #1;
        guard++;
        if (accepted) begin
          beat++;
          if (beat == int'(len) + 1) begin
            done = 1;
          end else if (resetAfter != 0 && beat == resetAfter) begin
            rst = 1'b1; arvalid = 1'b0; init_we = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0;
            checkOutput("rst_rvalid", rvalid, 0);
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_rlast", rlast, 0);
            checkOutput("rst_rdata", rdata, 0);
            checkOutput("rst_arready", arready, 1);
            repeat (3) begin
              @(posedge clk); #1;
              checkOutput("rst_quiet", rvalid, 0);
            end
            done = 1; aborted = 1;
          end
        end
      end
    end
    if (!aborted) begin
      init_we = 1'b0;
      if (!holdAr) arvalid = 1'b0;
      checkOutput("end_rvalid", rvalid, 0);
      checkOutput("end_rlast", rlast, 0);
      checkOutput("end_arready", arready, 1);
      checkOutput("end_busy", busy, 0);
      checkOutput("beat_count", beat, int'(len) + 1);
    end else begin
      checkOutput("beat_count_abort", beat, resetAfter);
    end
    rready = 1'b0;
  endtask

  initial begin
    checkCount = 0; passCount = 0;
    rst = 1'b1; arvalid = 1'b0; araddr = '0; arlen = '0; rready = 1'b0;
    init_we = 1'b0; init_addr = '0; init_data = '0;
    nextAddr = '0; nextLen = '0; junkIdx = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_rvalid", rvalid, 0);
    checkOutput("reset_rlast", rlast, 0);
    checkOutput("reset_rdata", rdata, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_arready", arready, 1);
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) loadWord(i, $urandom);

    // 8-beat line at word 0x40, full-rate then with backpressure.
    for (int i = 0; i < 8; i++) loadWord(32'h40 + i, 32'hA000_0000 + i);
    applyStimulus(32'h100, 8'd7, 0, 0, 0);
    applyStimulus(32'h100, 8'd7, 1, 0, 0);

    // Single beats, including ignored low address bits.
    applyStimulus(32'h0000_0204, 8'd0, 0, 0, 0);
    applyStimulus(32'h0000_0207, 8'd0, 2, 0, 0);

    // Index wrap and upper-address aliasing.
    applyStimulus(32'(1022 << 2), 8'd3, 0, 0, 0);
    applyStimulus(32'hFFFF_0000 | 32'(1022 << 2), 8'd3, 1, 0, 0);

    // Preload in the same cycle as the AR handshake must be visible to the burst.
    init_we = 1'b1; init_addr = DL'(10'h55); init_data = 32'h1234_5678;
    refMem[10'h55] = 32'h1234_5678;
    applyStimulus(32'(10'h55 << 2), 8'd1, 0, 0, 0);

    // Request pending during a burst; init_we in the burst must be ignored.
    junkIdx = DL'(10'h300); nextAddr = 32'(10'h300 << 2); nextLen = 8'd2;
    applyStimulus(32'h100, 8'd7, 2, 1, 0);
    applyStimulus(nextAddr, nextLen, 0, 0, 0);
    nextAddr = '0; nextLen = '0;

    // Reset mid-burst, then a normal single beat.
    applyStimulus(32'h100, 8'd7, 0, 0, 3);
    applyStimulus(32'h0000_0204, 8'd0, 0, 0, 0);

    for (int t = 0; t < 20; t++) begin
      loadWord($urandom_range(0, DEPTH - 1), $urandom);
      applyStimulus($urandom, 8'($urandom_range(0, 15)), int'($urandom_range(0, 2)), 0, 0);
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
